packet_source_arbiter: RTL and testbench
========================================

// Module: packet_source_arbiter
// PURPOSE
//   Shares one packet_splitter input between SOURCE_COUNT packet sources (FIFO-style, pop interface).
//   Grants whole packets round-robin, prepends a header word (magic, source index, per-source sequence
//   number) and forwards body words until the source marks end. Packets longer than MAX_WORDS are
//   truncated (forced end) and their remainder is drained and discarded. Sits between source FIFOs and the splitter.
// PARAMETERS
//   SOURCE_COUNT   4    number of requesters, 2..16
//   WORD_SIZE      32   word width = splitter SEGMENT_SIZE*SEGMENT_COUNT, >= 24
//   HEADER_ENABLE  1    1: emit header word before each packet; 0: body only
//   MAX_WORDS      256  max body words per packet, 2..65535
// PORTS
//   clk            in   1                    clock, all state on rising edge
//   rst_n          in   1                    asynchronous active-low reset
//   src_enable     in   SOURCE_COUNT         per-source grant mask, sampled only in IDLE
//   src_nempty     in   SOURCE_COUNT         source i has a word available
//   src_data       in   SOURCE_COUNT*WORD_SIZE  word of source i at [i*WORD_SIZE +: WORD_SIZE]
//   src_end        in   SOURCE_COUNT         current word of source i is last of packet
//   src_pop        out  SOURCE_COUNT         consume current word of source i (one-hot or zero)
//   dst_full       in   1                    splitter cannot accept a word
//   dst_shift      out  1                    word transferred to splitter this cycle
//   dst_data       out  WORD_SIZE            word to splitter
//   dst_end        out  1                    word is last of packet
//   busy           out  1                    state != IDLE
//   grant          out  clog2(SOURCE_COUNT)  index of current/last granted source
//   truncated      out  1                    one-cycle pulse when a packet is force-ended
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, grant=SOURCE_COUNT-1 (first scan starts at 0), seq counters 0,
//     word counter 0, truncated=0. Combinational outputs src_pop/dst_shift/dst_end=0 while IDLE.
//     Reset mid-packet abandons it; splitter sees no end word (splitter reset is its owner's concern).
//   - dst_shift only when !dst_full; dst_data/dst_end meaningful only when dst_shift=1.
//   - IDLE: req = src_nempty & src_enable. If req!=0, pick first set bit scanning grant+1, grant+2, ...
//     with wrap; register grant; next state HEADER (HEADER_ENABLE=1) else BODY. Word counter:=0.
//     Arbitration costs exactly one cycle; no transfer occurs in IDLE.
//   - HEADER: dst_shift=!dst_full, dst_data={8'hA5, zero pad, 8'(grant), 8'(seq[grant])}, dst_end=0,
//     no pop. On transfer -> BODY.
//   - BODY: dst_shift = src_nempty[grant] & !dst_full; src_pop[grant]=dst_shift; dst_data=src_data[grant].
//     dst_end = src_end[grant] | (word counter == MAX_WORDS-1). Each transfer increments word counter.
//     Transfer with src_end -> IDLE, seq[grant]+=1 (8-bit wrap 255->0).
//     Transfer with forced end and !src_end -> DRAIN, truncated=1 next cycle, seq[grant]+=1.
//     Source empty: wait indefinitely, no timeout; src_enable changes ignored.
//   - DRAIN: src_pop[grant]=src_nempty[grant], dst_shift=0; popping a word with src_end -> IDLE.
//   - A source whose end and forced end coincide is not truncated (src_end wins, no pulse).
//   - Fairness: after any packet from source g, every other requesting enabled source is served
//     before g again. Back-to-back packets: min 1 idle cycle between a packet end and next header.
// TESTING
//   1 Reset, src0 single packet A,B(end), dst_full=0 -> dst sees A5..00_00, A, B(end); src_pop[0] 2 pulses; busy 0 after.
//   2 All 4 sources hold 2-word packets -> grant order 0,1,2,3,0; headers carry seq 0,0,0,0,1.
//   3 dst_full toggles randomly during header/body -> no word lost/duplicated, order intact, no pop while full.
//   4 MAX_WORDS=4, src1 sends 6 words -> 4 body words, 4th dst_end=1, truncated pulse, 2 words drained, seq[1]=1.
//   5 src_enable=4'b1011 with all requesting -> source 2 never granted; cycles 0,1,3.
//   6 rst_n low mid-BODY -> outputs 0 immediately (async), grant=3, next grant goes to source 0.

Source files
------------

// File: rtl/packet_source_arbiter_if.sv
// Bundle of source-FIFO pop signals and splitter push signals around packet_source_arbiter.
// The master modport is the arbiter; the slave modport is whatever surrounds it.
interface packet_source_arbiter_if #(
  parameter int SOURCE_COUNT = 4,
  parameter int WORD_SIZE    = 32
);
  localparam int GW = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;

  logic [SOURCE_COUNT-1:0]           src_enable;
  logic [SOURCE_COUNT-1:0]           src_nempty;
  logic [SOURCE_COUNT*WORD_SIZE-1:0] src_data;
  logic [SOURCE_COUNT-1:0]           src_end;
  logic [SOURCE_COUNT-1:0]           src_pop;
  logic                              dst_full;
  logic                              dst_shift;
  logic [WORD_SIZE-1:0]              dst_data;
  logic                              dst_end;
  logic                              busy;
  logic [GW-1:0]                     grant;
  logic                              truncated;

  modport master (
    input  src_enable, src_nempty, src_data, src_end, dst_full,
    output src_pop, dst_shift, dst_data, dst_end, busy, grant, truncated
  );

  modport slave (
    output src_enable, src_nempty, src_data, src_end, dst_full,
    input  src_pop, dst_shift, dst_data, dst_end, busy, grant, truncated
  );
endinterface

// File: rtl/packet_source_arbiter.sv
// Round-robin whole-packet arbiter feeding one splitter input from several source FIFOs,
// with optional header word, per-source sequence numbers and length truncation.
module packet_source_arbiter #(
  parameter int SOURCE_COUNT  = 4,
  parameter int WORD_SIZE     = 32,
  parameter int HEADER_ENABLE = 1,
  parameter int MAX_WORDS     = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  packet_source_arbiter_if.master bus
);
  localparam int          GW       = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;
  localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_DRAIN} state_t;

  state_t                  r_state, w_state_next;
  logic [GW-1:0]           r_grant, w_pick;
  logic [7:0]              r_seq [SOURCE_COUNT];
  logic [15:0]             r_wcnt;
  logic                    r_truncated;

  logic [SOURCE_COUNT-1:0] w_req, w_pop;
  logic [WORD_SIZE-1:0]    w_words [SOURCE_COUNT];
  logic [WORD_SIZE-1:0]    w_cur_data, w_hdr, w_dst_data;
  logic [GW:0]             w_sum;
  logic                    w_found, w_cur_nempty, w_cur_end, w_forced;
  logic                    w_shift, w_dst_end, w_close;

  assign w_req = bus.src_nempty & bus.src_enable;

  genvar gi;
  generate
    for (gi = 0; gi < SOURCE_COUNT; gi++) begin : g_word
      assign w_words[gi] = bus.src_data[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign w_cur_data   = w_words[r_grant];
  assign w_cur_nempty = bus.src_nempty[r_grant];
  assign w_cur_end    = bus.src_end[r_grant];
  assign w_forced     = (r_wcnt == LAST_IDX);

  // Scan starts one past the last grant so the last-served source goes to the back of the line.
  always_comb begin
    w_pick  = r_grant;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 1; k <= SOURCE_COUNT; k++) begin
      w_sum = {1'b0, r_grant} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(SOURCE_COUNT))
        w_sum = w_sum - (GW+1)'(SOURCE_COUNT);
      if (!w_found && w_req[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_hdr                     = '0;
    w_hdr[WORD_SIZE-1 -: 8]   = 8'hA5;
    w_hdr[15:8]               = 8'(r_grant);
    w_hdr[7:0]                = r_seq[r_grant];
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = '0;
    w_shift      = 1'b0;
    w_dst_end    = 1'b0;
    w_dst_data   = w_cur_data;
    w_close      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found)
          w_state_next = (HEADER_ENABLE != 0) ? S_HEADER : S_BODY;
      end
      S_HEADER: begin
        w_shift    = !bus.dst_full;
        w_dst_data = w_hdr;
        if (w_shift)
          w_state_next = S_BODY;
      end
      S_BODY: begin
        w_shift          = w_cur_nempty && !bus.dst_full;
        w_pop[r_grant]   = w_shift;
        w_dst_end        = w_cur_end || w_forced;
        w_close          = w_shift && (w_cur_end || w_forced);
        if (w_shift && w_cur_end)
          w_state_next = S_IDLE;
        else if (w_shift && w_forced)
          w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Discard the rest of a truncated packet regardless of splitter backpressure.
        w_pop[r_grant] = w_cur_nempty;
        if (w_cur_nempty && w_cur_end)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= GW'(SOURCE_COUNT - 1);
      r_wcnt      <= '0;
      r_truncated <= 1'b0;
      for (int i = 0; i < SOURCE_COUNT; i++)
        r_seq[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_truncated <= 1'b0;
      if (r_state == S_IDLE) begin
        r_wcnt <= '0;
        if (w_found)
          r_grant <= w_pick;
      end
      if (r_state == S_BODY && w_shift) begin
        r_wcnt <= r_wcnt + 16'd1;
        if (w_forced && !w_cur_end)
          r_truncated <= 1'b1;
      end
      if (w_close)
        r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
    end
  end

  assign bus.src_pop   = w_pop;
  assign bus.dst_shift = w_shift;
  assign bus.dst_data  = w_dst_data;
  assign bus.dst_end   = w_dst_end;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant     = r_grant;
  assign bus.truncated = r_truncated;

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Directed bench for packet_source_arbiter (4 sources, 32-bit words, header on, MAX_WORDS=4).
// Source FIFOs are modelled as small arrays; splitter output is captured and compared to hand-built lists.
module tb_packet_source_arbiter;
  localparam int SC = 4;
  localparam int WS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_source_arbiter_if #(.SOURCE_COUNT(SC), .WORD_SIZE(WS)) bus ();

  packet_source_arbiter #(
    .SOURCE_COUNT(SC), .WORD_SIZE(WS), .HEADER_ENABLE(1), .MAX_WORDS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Source FIFO model
  logic [31:0] mem_data [SC][16];
  logic        mem_end  [SC][16];
  int          wr [SC];
  int          rd [SC];

  always_comb begin
    bus.src_nempty = '0;
    bus.src_end    = '0;
    bus.src_data   = '0;
    for (int i = 0; i < SC; i++) begin
      bus.src_nempty[i]        = (rd[i] < wr[i]);
      bus.src_end[i]           = mem_end[i][rd[i][3:0]];
      bus.src_data[i*WS +: WS] = mem_data[i][rd[i][3:0]];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SC; i++) rd[i] <= 0;
    end else begin
      for (int i = 0; i < SC; i++)
        if (bus.src_pop[i]) rd[i] <= rd[i] + 1;
    end
  end

  // Splitter-side monitor
  logic [32:0] cap [256];
  int   cap_n = 0;
  int   pops [SC] = '{default: 0};
  int   trunc_cyc = 0;
  int   gap_err = 0;
  int   full_pop = 0;
  logic prev_end = 1'b0;

  always @(posedge clk) begin
    if (bus.dst_shift) begin
      cap[cap_n] <= {bus.dst_end, bus.dst_data};
      cap_n      <= cap_n + 1;
    end
    for (int i = 0; i < SC; i++)
      if (bus.src_pop[i]) pops[i] <= pops[i] + 1;
    if (bus.truncated) trunc_cyc <= trunc_cyc + 1;
    if (bus.dst_shift && prev_end) gap_err <= gap_err + 1;
    prev_end <= bus.dst_shift & bus.dst_end;
    if ((|bus.src_pop) && bus.dst_full) full_pop <= full_pop + 1;
  end

  // Backpressure driver: deterministic irregular pattern when enabled
  bit full_mode = 1'b0;
  int fcyc = 0;
  always @(negedge clk) begin
    bus.dst_full = full_mode && (((fcyc % 3) == 0) || ((fcyc % 5) == 1));
    fcyc = fcyc + 1;
  end

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push(input int s, input logic [31:0] d, input logic e);
    mem_data[s][wr[s]] = d;
    mem_end[s][wr[s]]  = e;
    wr[s]++;
  endtask

  task automatic expect_w(input logic e, input logic [31:0] d);
    exp_q.push_back({e, d});
  endtask

  task automatic wait_done(input string t, input int target);
    int c;
    c = 0;
    @(negedge clk);
    while (!(cap_n >= target && !bus.busy) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) check({t, " timeout"}, 64'(cap_n), 64'(target));
  endtask

  task automatic compare(input string t, input int base);
    int n;
    n = exp_q.size();
    check($sformatf("%s count", t), 64'(cap_n - base), 64'(n));
    for (int k = 0; k < n; k++)
      check($sformatf("%s word%0d", t, k), 64'(cap[base + k]), 64'(exp_q[k]));
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < SC; i++) wr[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base, p0, p1, p2, t0, c;
    bus.src_enable = '1;
    for (int i = 0; i < SC; i++) wr[i] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst grant", 64'(bus.grant), 64'd3);
    check("rst truncated", 64'(bus.truncated), 64'd0);
    check("rst dst_shift", 64'(bus.dst_shift), 64'd0);
    check("rst src_pop", 64'(bus.src_pop), 64'd0);
    rst_n = 1'b1;

    // 1: single packet from source 0
    base = cap_n; p0 = pops[0];
    @(negedge clk);
    push(0, 32'h1111_000A, 1'b0);
    push(0, 32'h1111_000B, 1'b1);
    expect_w(1'b0, 32'hA500_0000);
    expect_w(1'b0, 32'h1111_000A);
    expect_w(1'b1, 32'h1111_000B);
    wait_done("t1", base + 3);
    compare("t1", base);
    check("t1 pops0", 64'(pops[0] - p0), 64'd2);
    check("t1 busy", 64'(bus.busy), 64'd0);

    // 2: all four sources, source 0 has a second packet
    do_reset();
    base = cap_n;
    @(negedge clk);
    for (int s = 0; s < SC; s++) begin
      push(s, 32'h2000_0000 | 32'(s << 8), 1'b0);
      push(s, 32'h2000_0001 | 32'(s << 8), 1'b1);
    end
    push(0, 32'h2000_1000, 1'b0);
    push(0, 32'h2000_1001, 1'b1);
    for (int s = 0; s < SC; s++) begin
      expect_w(1'b0, 32'hA500_0000 | 32'(s << 8));
      expect_w(1'b0, 32'h2000_0000 | 32'(s << 8));
      expect_w(1'b1, 32'h2000_0001 | 32'(s << 8));
    end
    expect_w(1'b0, 32'hA500_0001);
    expect_w(1'b0, 32'h2000_1000);
    expect_w(1'b1, 32'h2000_1001);
    wait_done("t2", base + 15);
    compare("t2", base);
    check("t2 gap", 64'(gap_err), 64'd0);

    // 3: backpressure during header and body, sources 2 and 3 (seq already 1)
    base = cap_n;
    full_mode = 1'b1;
    @(negedge clk);
    push(2, 32'h3000_0200, 1'b0);
    push(2, 32'h3000_0201, 1'b0);
    push(2, 32'h3000_0202, 1'b1);
    push(3, 32'h3000_0300, 1'b0);
    push(3, 32'h3000_0301, 1'b1);
    expect_w(1'b0, 32'hA500_0201);
    expect_w(1'b0, 32'h3000_0200);
    expect_w(1'b0, 32'h3000_0201);
    expect_w(1'b1, 32'h3000_0202);
    expect_w(1'b0, 32'hA500_0301);
    expect_w(1'b0, 32'h3000_0300);
    expect_w(1'b1, 32'h3000_0301);
    wait_done("t3", base + 7);
    full_mode = 1'b0;
    compare("t3", base);
    check("t3 pop while full", 64'(full_pop), 64'd0);
    check("t3 gap", 64'(gap_err), 64'd0);

    // 4: 6-word packet truncated to 4, then an exact 4-word packet
    do_reset();
    base = cap_n; t0 = trunc_cyc; p1 = pops[1];
    @(negedge clk);
    for (int k = 0; k < 6; k++) push(1, 32'h4000_0100 + 32'(k), (k == 5));
    expect_w(1'b0, 32'hA500_0100);
    expect_w(1'b0, 32'h4000_0100);
    expect_w(1'b0, 32'h4000_0101);
    expect_w(1'b0, 32'h4000_0102);
    expect_w(1'b1, 32'h4000_0103);
    wait_done("t4a", base + 5);
    check("t4 trunc pulse", 64'(trunc_cyc - t0), 64'd1);
    check("t4 pops1", 64'(pops[1] - p1), 64'd6);
    check("t4 grant", 64'(bus.grant), 64'd1);
    for (int k = 0; k < 4; k++) push(1, 32'h4000_0200 + 32'(k), (k == 3));
    expect_w(1'b0, 32'hA500_0101);
    expect_w(1'b0, 32'h4000_0200);
    expect_w(1'b0, 32'h4000_0201);
    expect_w(1'b0, 32'h4000_0202);
    expect_w(1'b1, 32'h4000_0203);
    wait_done("t4b", base + 10);
    compare("t4", base);
    check("t4 no trunc exact", 64'(trunc_cyc - t0), 64'd1);

    // 5: source 2 masked off
    do_reset();
    base = cap_n; p2 = pops[2];
    bus.src_enable = 4'b1011;
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < SC; s++)
        push(s, 32'h5000_0000 | 32'(s << 8) | 32'(p), 1'b1);
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < SC; s++) begin
        if (s != 2) begin
          expect_w(1'b0, 32'hA500_0000 | 32'(s << 8) | 32'(p));
          expect_w(1'b1, 32'h5000_0000 | 32'(s << 8) | 32'(p));
        end
      end
    end
    wait_done("t5", base + 12);
    compare("t5", base);
    check("t5 src2 pops", 64'(pops[2] - p2), 64'd0);

    // 6: asynchronous reset in the middle of a body
    do_reset();
    bus.src_enable = '1;
    base = cap_n;
    @(negedge clk);
    for (int k = 0; k < 4; k++) push(1, 32'h6000_0100 + 32'(k), (k == 3));
    c = 0;
    while (cap_n < base + 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) check("t6 body timeout", 64'(cap_n - base), 64'd2);
    check("t6 pre shift", 64'(bus.dst_shift), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async shift", 64'(bus.dst_shift), 64'd0);
    check("t6 async pop", 64'(bus.src_pop), 64'd0);
    check("t6 async busy", 64'(bus.busy), 64'd0);
    check("t6 async grant", 64'(bus.grant), 64'd3);
    for (int i = 0; i < SC; i++) wr[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = cap_n;
    @(negedge clk);
    push(3, 32'h6000_0300, 1'b1);
    push(0, 32'h6000_0000, 1'b1);
    expect_w(1'b0, 32'hA500_0000);
    expect_w(1'b1, 32'h6000_0000);
    expect_w(1'b0, 32'hA500_0300);
    expect_w(1'b1, 32'h6000_0300);
    wait_done("t6", base + 4);
    compare("t6", base);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
